// File: rtl/map_table_ckpt.sv
// Register alias table: maps each architectural register to the ROB tag that produces it (0 = in regfile),
// with a circular bank of full-table checkpoints for single-cycle mispredict recovery.
module map_table_ckpt #(
  parameter int ROBsize      = 16,
  parameter int tagW         = $clog2(ROBsize + 1),
  parameter int numArchRegs  = 32,
  parameter int addrW        = $clog2(numArchRegs),
  parameter int numReadPorts = 2,
  parameter int numCkpts     = 4,
  parameter int zeroReg      = 31
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [numReadPorts-1:0][addrW-1:0]  readAddr_i,
  output logic [numReadPorts-1:0][tagW-1:0]   readData_o,
  input  logic                                writeEn_i,
  input  logic [addrW-1:0]                    writeAddr_i,
  input  logic [tagW-1:0]                     writeData_i,
  input  logic                                commitEn_i,
  input  logic [addrW-1:0]                    commitAddr_i,
  input  logic [tagW-1:0]                     commitTag_i,
  output logic [tagW-1:0]                     commitData_o,
  input  logic                                ckptSave_i,
  output logic [$clog2(numCkpts)-1:0]         ckptSaveId_o,
  input  logic                                ckptRestore_i,
  input  logic [$clog2(numCkpts)-1:0]         ckptRestoreId_i,
  input  logic                                ckptRelease_i,
  input  logic                                flush_i,
  output logic [$clog2(numCkpts):0]           ckptCount_o,
  output logic                                ckptFull_o
);
  localparam int idW = $clog2(numCkpts);

  typedef logic [numArchRegs-1:0][tagW-1:0] image_t;

  image_t                    table_reg;
  image_t                    table_next;
  image_t [numCkpts-1:0]     ckpt_reg;
  logic [idW-1:0]            head_reg;
  logic [idW-1:0]            tail_reg;
  logic [idW:0]              count_reg;
  logic [idW-1:0]            restore_dist;
  logic                      restore_ok;
  logic                      save_ok;
  logic                      release_ok;

  // A slot is live when its distance from head (mod numCkpts) is below count.
  assign restore_dist = ckptRestoreId_i - head_reg;
  assign restore_ok   = ckptRestore_i && ({1'b0, restore_dist} < count_reg);
  assign save_ok      = ckptSave_i && !flush_i && !restore_ok &&
                        (count_reg < (idW+1)'(numCkpts));
  assign release_ok   = ckptRelease_i && !flush_i && !restore_ok && (count_reg != '0);

  always_comb begin
    table_next = restore_ok ? ckpt_reg[ckptRestoreId_i] : table_reg;
    if (commitEn_i && (table_next[commitAddr_i] == commitTag_i))
      table_next[commitAddr_i] = '0;
    // The write wins over a same-cycle commit clear; a restore discards it.
    if (writeEn_i && !restore_ok && (writeAddr_i != addrW'(zeroReg)))
      table_next[writeAddr_i] = writeData_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i)
      table_reg <= '0;
    else
      table_reg <= table_next;
  end

  // Scrubbing dead slots too is harmless: a dead slot is always reloaded by a save before it can be read.
  always_ff @(posedge clk) begin
    if (reset) begin
      ckpt_reg <= '0;
    end else begin
      for (int s = 0; s < numCkpts; s++) begin
        if (save_ok && (tail_reg == idW'(s)))
          ckpt_reg[s] <= table_next;
        else if (commitEn_i && (ckpt_reg[s][commitAddr_i] == commitTag_i))
          ckpt_reg[s][commitAddr_i] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (restore_ok) begin
      tail_reg  <= ckptRestoreId_i;
      count_reg <= {1'b0, restore_dist};
    end else begin
      if (save_ok)
        tail_reg <= tail_reg + idW'(1);
      if (release_ok)
        head_reg <= head_reg + idW'(1);
      case ({save_ok, release_ok})
        2'b10:   count_reg <= count_reg + (idW+1)'(1);
        2'b01:   count_reg <= count_reg - (idW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < numReadPorts; gi++) begin : g_rd
      assign readData_o[gi] = table_reg[readAddr_i[gi]];
    end
  endgenerate

  assign commitData_o = table_reg[commitAddr_i];
  assign ckptSaveId_o = tail_reg;
  assign ckptCount_o  = count_reg;
  assign ckptFull_o   = (count_reg == (idW+1)'(numCkpts));

endmodule
